// File: rtl/refill_victim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : refill_victim_ctrl
// Purpose  : Line-refill controller for set-associative caches and TLBs.
//            On a miss it picks a victim way (lowest invalid way first, else
//            the PLRU victim), fetches the line through a request/grant and
//            read-valid handshake, streams the beats into the data array and
//            pulses the filled way back to the PLRU tree and the requester.
// Ports    : clk, rst_n                   clock, async active-low reset
//            miss_valid_i/miss_ready_o    miss handshake
//            miss_addr_i                  missing address
//            way_valid_i, plru_i          set state sampled at acceptance
//            used_o                       one-hot PLRU update pulse
//            mem_req_o/mem_addr_o/mem_gnt_i  refill request handshake
//            mem_rvalid_i/mem_rdata_i     returning read beats
//            wr_en_o/wr_way_o/wr_beat_o/wr_data_o  data-array write port
//            done_o/done_way_o            refill-complete pulse
// Revision : 1.0 - initial release
// ============================================================================
module refill_victim_ctrl #(
  parameter int WAYS   = 4,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_valid_i,
  output logic                     miss_ready_o,
  input  logic [ADDR_W-1:0]        miss_addr_i,
  input  logic [WAYS-1:0]          way_valid_i,
  input  logic [WAYS-1:0]          plru_i,
  output logic [WAYS-1:0]          used_o,
  output logic                     mem_req_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  input  logic                     mem_rvalid_i,
  input  logic [DATA_W-1:0]        mem_rdata_i,
  output logic                     wr_en_o,
  output logic [WAYS-1:0]          wr_way_o,
  output logic [$clog2(BEATS)-1:0] wr_beat_o,
  output logic [DATA_W-1:0]        wr_data_o,
  output logic                     done_o,
  output logic [WAYS-1:0]          done_way_o
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int OFF_W  = BEAT_W + $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0]  C_LINE_MASK = {ADDR_W{1'b1}} << OFF_W;
  localparam logic [BEAT_W-1:0]  C_LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              r_state;
  logic [WAYS-1:0]     r_victim;
  logic [BEAT_W-1:0]   r_beat;
  logic [WAYS-1:0]     w_new_victim;
  logic                w_found;
  logic                w_fill;

  // Victim choice: lowest invalid way wins; otherwise the lowest set bit of
  // the PLRU vector (which is plru_i itself when it is one-hot); a zero PLRU
  // vector falls back to way 0 so the result is always exactly one-hot.
  always_comb begin
    w_new_victim = '0;
    w_found      = 1'b0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_found && !way_valid_i[i]) begin
        w_new_victim[i] = 1'b1;
        w_found         = 1'b1;
      end
    end
    for (int i = 0; i < WAYS; i++) begin
      if (!w_found && plru_i[i]) begin
        w_new_victim[i] = 1'b1;
        w_found         = 1'b1;
      end
    end
    if (!w_found) begin
      w_new_victim[0] = 1'b1;
    end
  end

  // Write port is a same-cycle pass-through of the returning beat.
  assign w_fill    = (r_state == FILL);
  assign wr_en_o   = w_fill & mem_rvalid_i;
  assign wr_beat_o = r_beat;
  assign wr_data_o = w_fill ? mem_rdata_i : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_victim     <= '0;
      r_beat       <= '0;
      miss_ready_o <= 1'b1;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      wr_way_o     <= '0;
      used_o       <= '0;
      done_o       <= 1'b0;
      done_way_o   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_valid_i) begin
            mem_addr_o   <= miss_addr_i & C_LINE_MASK;
            r_victim     <= w_new_victim;
            miss_ready_o <= 1'b0;
            mem_req_o    <= 1'b1;
            r_state      <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            r_beat    <= '0;
            wr_way_o  <= r_victim;
            r_state   <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid_i) begin
            // Counter wraps to 0 naturally on the last beat.
            r_beat <= r_beat + 1'b1;
            if (r_beat == C_LAST_BEAT) begin
              wr_way_o   <= '0;
              done_o     <= 1'b1;
              done_way_o <= r_victim;
              used_o     <= r_victim;
              r_state    <= DONE;
            end
          end
        end
        DONE: begin
          done_o       <= 1'b0;
          done_way_o   <= '0;
          used_o       <= '0;
          miss_ready_o <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          miss_ready_o <= 1'b1;
          mem_req_o    <= 1'b0;
          wr_way_o     <= '0;
          used_o       <= '0;
          done_o       <= 1'b0;
          done_way_o   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_refill_victim_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_refill_victim_ctrl
// Purpose  : Directed self-checking bench for refill_victim_ctrl
//            (WAYS=4, BEATS=4, ADDR_W=32, DATA_W=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_refill_victim_ctrl;

  logic        clk;
  logic        rst_n;
  logic        miss_valid_i;
  logic        miss_ready_o;
  logic [31:0] miss_addr_i;
  logic [3:0]  way_valid_i;
  logic [3:0]  plru_i;
  logic [3:0]  used_o;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wr_en_o;
  logic [3:0]  wr_way_o;
  logic [1:0]  wr_beat_o;
  logic [31:0] wr_data_o;
  logic        done_o;
  logic [3:0]  done_way_o;

  int nvec;
  int nerr;

  refill_victim_ctrl #(
    .WAYS  (4),
    .BEATS (4),
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .miss_valid_i(miss_valid_i),
    .miss_ready_o(miss_ready_o),
    .miss_addr_i (miss_addr_i),
    .way_valid_i (way_valid_i),
    .plru_i      (plru_i),
    .used_o      (used_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .wr_en_o     (wr_en_o),
    .wr_way_o    (wr_way_o),
    .wr_beat_o   (wr_beat_o),
    .wr_data_o   (wr_data_o),
    .done_o      (done_o),
    .done_way_o  (done_way_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"},    64'(miss_ready_o), 64'd1);
    chk({tag, ".req"},      64'(mem_req_o),    64'd0);
    chk({tag, ".addr"},     64'(mem_addr_o),   64'd0);
    chk({tag, ".wr_en"},    64'(wr_en_o),      64'd0);
    chk({tag, ".wr_way"},   64'(wr_way_o),     64'd0);
    chk({tag, ".wr_beat"},  64'(wr_beat_o),    64'd0);
    chk({tag, ".used"},     64'(used_o),       64'd0);
    chk({tag, ".done"},     64'(done_o),       64'd0);
    chk({tag, ".done_way"}, 64'(done_way_o),   64'd0);
  endtask

  // Minimum-latency refill: grant in the first REQ cycle, back-to-back beats.
  // way_valid_i / plru_i are scrambled after acceptance to show they are
  // sampled only in the acceptance cycle.
  task automatic refill_min(input string tag, input logic [31:0] addr,
                            input logic [3:0] wv, input logic [3:0] plru,
                            input logic [3:0] exp_victim, input logic [31:0] exp_addr);
    miss_valid_i = 1'b1;
    miss_addr_i  = addr;
    way_valid_i  = wv;
    plru_i       = plru;
    #1;
    chk({tag, ".ready_idle"}, 64'(miss_ready_o), 64'd1);
    tick();                                   // T+1
    miss_valid_i = 1'b0;
    way_valid_i  = 4'b0000;
    plru_i       = 4'b0100;
    chk({tag, ".req"},  64'(mem_req_o),  64'd1);
    chk({tag, ".addr"}, 64'(mem_addr_o), 64'(exp_addr));
    chk({tag, ".ready_req"}, 64'(miss_ready_o), 64'd0);
    mem_gnt_i = 1'b1;
    tick();                                   // T+2, FILL
    mem_gnt_i = 1'b0;
    chk({tag, ".req_drop"}, 64'(mem_req_o), 64'd0);
    for (int b = 0; b < 4; b++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hC0DE_0000 + 32'(b);
      #1;
      chk({tag, ".wr_en"},   64'(wr_en_o),   64'd1);
      chk({tag, ".wr_way"},  64'(wr_way_o),  64'(exp_victim));
      chk({tag, ".wr_beat"}, 64'(wr_beat_o), 64'(b));
      chk({tag, ".wr_data"}, 64'(wr_data_o), 64'(32'hC0DE_0000 + 32'(b)));
      chk({tag, ".done_early"}, 64'(done_o), 64'd0);
      tick();
    end
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    // T+6: DONE
    chk({tag, ".done"},     64'(done_o),     64'd1);
    chk({tag, ".used"},     64'(used_o),     64'(exp_victim));
    chk({tag, ".done_way"}, 64'(done_way_o), 64'(exp_victim));
    chk({tag, ".wr_way_done"}, 64'(wr_way_o), 64'd0);
    chk({tag, ".ready_done"},  64'(miss_ready_o), 64'd0);
    tick();
    chk({tag, ".used_clr"},  64'(used_o),       64'd0);
    chk({tag, ".done_clr"},  64'(done_o),       64'd0);
    chk({tag, ".ready_ret"}, 64'(miss_ready_o), 64'd1);
  endtask

  initial begin
    nvec         = 0;
    nerr         = 0;
    rst_n        = 1'b0;
    miss_valid_i = 1'b0;
    miss_addr_i  = 32'h0;
    way_valid_i  = 4'h0;
    plru_i       = 4'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;

    // Reset state
    tick();
    chk_reset_outputs("reset");
    tick();
    rst_n = 1'b1;
    tick();
    chk_reset_outputs("post_reset");

    // Invalid way preferred over PLRU; line-aligned address
    refill_min("inv_way", 32'h1234_567C, 4'b1011, 4'b0001, 4'b0100, 32'h1234_5670);

    // All valid, one-hot PLRU, minimum latency
    refill_min("plru_1hot", 32'hDEAD_BEEF, 4'b1111, 4'b1000, 4'b1000, 32'hDEAD_BEE0);

    // PLRU zero -> way 0; multi-bit PLRU -> lowest set bit
    refill_min("plru_zero", 32'h0000_0010, 4'b1111, 4'b0000, 4'b0001, 32'h0000_0010);
    refill_min("plru_multi", 32'hFFFF_FFFF, 4'b1111, 4'b0110, 4'b0010, 32'hFFFF_FFF0);

    // Delayed grant, rvalid ignored in REQ, gapped beats
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'hA5A5_5A5B;
    way_valid_i  = 4'b1110;
    plru_i       = 4'b1000;
    tick();
    miss_valid_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hBAD0_0000;
      #1;
      chk("dly.req_hold",  64'(mem_req_o),  64'd1);
      chk("dly.addr_hold", 64'(mem_addr_o), 64'hA5A5_5A50);
      chk("dly.no_wr_req", 64'(wr_en_o),    64'd0);
      tick();
    end
    mem_rvalid_i = 1'b0;
    mem_gnt_i    = 1'b1;
    #1;
    chk("dly.req_at_gnt", 64'(mem_req_o), 64'd1);
    tick();
    mem_gnt_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      for (int g = 0; g < 2; g++) begin
        mem_rvalid_i = 1'b0;
        #1;
        chk("dly.gap_no_wr",   64'(wr_en_o),   64'd0);
        chk("dly.gap_beat",    64'(wr_beat_o), 64'(b));
        tick();
      end
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'h5000_0000 + 32'(b);
      #1;
      chk("dly.wr_en",   64'(wr_en_o),   64'd1);
      chk("dly.wr_beat", 64'(wr_beat_o), 64'(b));
      chk("dly.wr_way",  64'(wr_way_o),  64'b0001);
      tick();
    end
    mem_rvalid_i = 1'b0;
    chk("dly.done", 64'(done_o), 64'd1);
    chk("dly.used", 64'(used_o), 64'b0001);
    tick();
    chk("dly.used_once", 64'(used_o), 64'd0);

    // miss_valid held high: ready low throughout, second miss at L+2
    miss_valid_i = 1'b1;
    miss_addr_i  = 32'h0000_1000;
    way_valid_i  = 4'b0111;
    plru_i       = 4'b0001;
    tick();
    chk("hold.ready_req", 64'(miss_ready_o), 64'd0);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mem_rvalid_i = 1'b1;
      #1;
      chk("hold.ready_fill", 64'(miss_ready_o), 64'd0);
      tick();
    end
    mem_rvalid_i = 1'b0;
    chk("hold.ready_done", 64'(miss_ready_o), 64'd0);
    chk("hold.used",       64'(used_o),       64'b1000);
    tick();                                   // L+2
    chk("hold.ready_l2",   64'(miss_ready_o), 64'd1);
    chk("hold.req_l2",     64'(mem_req_o),    64'd0);
    miss_addr_i = 32'h0000_2004;
    way_valid_i = 4'b1111;
    plru_i      = 4'b0100;
    tick();
    miss_valid_i = 1'b0;
    chk("hold.second_req",  64'(mem_req_o),  64'd1);
    chk("hold.second_addr", 64'(mem_addr_o), 64'h0000_2000);

    // Asynchronous reset in FILL after beat 1, then stray beats ignored
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_rvalid_i = 1'b1;
      tick();
    end
    mem_rvalid_i = 1'b0;
    #1;
    chk("arst.pre_way", 64'(wr_way_o), 64'b0100);
    chk("arst.pre_beat", 64'(wr_beat_o), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("arst");
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hFEED_0000 + 32'(c);
      #1;
      chk("arst.stray_wr",    64'(wr_en_o),      64'd0);
      chk("arst.stray_ready", 64'(miss_ready_o), 64'd1);
      chk("arst.stray_req",   64'(mem_req_o),    64'd0);
      tick();
    end
    mem_rvalid_i = 1'b0;
    chk("arst.no_done", 64'(done_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
